// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse generator and lock qualifier: pulses PLL RESET, waits for a stable
// synchronised lock, then releases the downstream reset while lock holds.
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 2500000,
    parameter int unsigned STABLE_CYCLES = 65536,
    parameter int unsigned CNT_W         = 22,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_lock,
    input  logic             soft_rst_req,
    output logic             pll_reset,
    output logic             sys_rst_n,
    output logic             locked,
    output logic [1:0]       state,
    output logic [ERR_W-1:0] loss_count,
    output logic [ERR_W-1:0] timeout_count
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'b00,
        WAIT_LOCK = 2'b01,
        STABLE    = 2'b10,
        RUN       = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX      = {ERR_W{1'b1}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   loss_q, loss_d;
    logic [ERR_W-1:0]   tmo_q, tmo_d;
    logic               sync1_q, lock_s_q;
    logic               pll_reset_q, run_q;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Next-state, counter and error-count logic; soft request overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        tmo_d   = tmo_q;
        if (soft_rst_req) begin
            state_d = PLL_RST;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = STABLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = PLL_RST;
                        cnt_d   = {CNT_W{1'b0}};
                        tmo_d   = (tmo_q == ERR_MAX) ? tmo_q : tmo_q + ERR_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s_q) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = {CNT_W{1'b0}};
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    cnt_d = {CNT_W{1'b0}};
                    if (!lock_s_q) begin
                        state_d = PLL_RST;
                        loss_d  = (loss_q == ERR_MAX) ? loss_q : loss_q + ERR_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counters and output flops; outputs are decoded from the next state
    // so they change on the same edge as the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= PLL_RST;
            cnt_q       <= {CNT_W{1'b0}};
            loss_q      <= {ERR_W{1'b0}};
            tmo_q       <= {ERR_W{1'b0}};
            pll_reset_q <= 1'b1;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            tmo_q       <= tmo_d;
            pll_reset_q <= (state_d == PLL_RST);
            run_q       <= (state_d == RUN);
        end
    end

    assign pll_reset     = pll_reset_q;
    assign sys_rst_n     = run_q;
    assign locked        = run_q;
    assign state         = state_q;
    assign loss_count    = loss_q;
    assign timeout_count = tmo_q;

endmodule
